// File: rtl/mole_spawner.sv
// Spawn scheduler for the mole array: paces attempts by difficulty level, picks an
// empty hole from an LFSR-seeded scan and holds a one-hot start until a mole accepts.
module mole_spawner #(
  parameter int          NUM_MOLES     = 9,
  parameter int          BASE_INTERVAL = 12,
  parameter int          MAX_ACTIVE    = 3,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                   animation_clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   pause,
  input  logic [1:0]             level,
  input  logic [2*NUM_MOLES-1:0] mole_state,
  output logic [NUM_MOLES-1:0]   start,
  output logic [7:0]             spawn_count,
  output logic                   busy
);

  localparam int          CNT_W     = $clog2(BASE_INTERVAL + 1);
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef enum logic [1:0] {IDLE, WAIT, PICK, ISSUE} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [3:0]           cand_q, cand_d;
  logic [3:0]           scan_q, scan_d;
  logic [3:0]           tmo_q, tmo_d;
  logic [NUM_MOLES-1:0] start_q, start_d;
  logic [7:0]           spawn_q, spawn_d;
  logic [15:0]          lfsr_q;

  logic [CNT_W-1:0]     interval_m1;
  logic [3:0]           lfsr_cand;
  logic [1:0]           cand_state;
  logic [4:0]           active;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    logic [15:0] n;
    n = v[0] ? ((v >> 1) ^ LFSR_MASK) : (v >> 1);
    return (n == 16'h0000) ? LFSR_SEED : n;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign interval_m1 = CNT_W'(BASE_INTERVAL - 1) - CNT_W'({level, 1'b0});
  assign lfsr_cand   = ({1'b0, lfsr_q[3:0]} >= 5'(NUM_MOLES)) ?
                       4'(lfsr_q[3:0] - 4'(NUM_MOLES)) : lfsr_q[3:0];
  assign cand_state  = 2'(mole_state >> {cand_q, 1'b0});

  always_comb begin
    active = '0;
    for (int i = 0; i < NUM_MOLES; i++)
      active = active + {4'd0, |mole_state[2*i +: 2]};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    scan_d  = scan_q;
    tmo_d   = tmo_q;
    start_d = start_q;
    spawn_d = spawn_q;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      scan_d  = '0;
      tmo_d   = '0;
      start_d = '0;
    end else if (!pause) begin
      case (state_q)
        IDLE: begin
          state_d = WAIT;
          cnt_d   = '0;
        end
        WAIT: begin
          // >= so a level raised mid-wait past the new limit fires at once
          if (cnt_q >= interval_m1) begin
            cnt_d   = '0;
            state_d = PICK;
            cand_d  = lfsr_cand;
            scan_d  = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        PICK: begin
          if (active >= 5'(MAX_ACTIVE)) begin
            state_d = WAIT;
          end else if (cand_state == 2'b00) begin
            state_d = ISSUE;
            tmo_d   = '0;
            start_d = {{(NUM_MOLES-1){1'b0}}, 1'b1} << cand_q;
          end else if (scan_q == 4'(NUM_MOLES - 2)) begin
            state_d = WAIT;
          end else begin
            cand_d = (cand_q == 4'(NUM_MOLES - 1)) ? 4'd0 : cand_q + 4'd1;
            scan_d = scan_q + 4'd1;
          end
        end
        ISSUE: begin
          // acceptance wins over a simultaneous timeout
          if (cand_state != 2'b00) begin
            start_d = '0;
            spawn_d = sat_inc(spawn_q);
            state_d = WAIT;
          end else if (tmo_q == 4'd15) begin
            start_d = '0;
            state_d = WAIT;
          end else begin
            tmo_d = tmo_q + 4'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge animation_clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cand_q  <= '0;
      scan_q  <= '0;
      tmo_q   <= '0;
      start_q <= '0;
      spawn_q <= '0;
      lfsr_q  <= LFSR_SEED;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      scan_q  <= scan_d;
      tmo_q   <= tmo_d;
      start_q <= start_d;
      spawn_q <= spawn_d;
      lfsr_q  <= lfsr_next(lfsr_q);
    end
  end

  assign start       = start_q;
  assign spawn_count = spawn_q;
  assign busy        = (state_q == PICK) || (state_q == ISSUE);

endmodule

// File: tb/tb_mole_spawner.sv
// Scoreboard bench for mole_spawner: directed scenarios push expected start-edge
// events; a monitor pops them whenever a DUT's start vector changes.
module tb_mole_spawner;

  logic        clk;
  logic        rst;
  logic        enable, enable2, pause;
  logic [1:0]  level;
  logic [17:0] mole_state;
  logic [8:0]  start1, start2;
  logic [7:0]  cnt1, cnt2;
  logic        busy1, busy2;
  int          frame;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int         dut;
    int         frame;
    logic [8:0] start;
    logic [7:0] cnt;
    logic       busy;
    int         id;
  } ev_t;
  ev_t exp_q[$];

  mole_spawner dut (
    .animation_clk(clk), .rst(rst), .enable(enable), .pause(pause), .level(level),
    .mole_state(mole_state), .start(start1), .spawn_count(cnt1), .busy(busy1)
  );

  mole_spawner #(.MAX_ACTIVE(9)) dut2 (
    .animation_clk(clk), .rst(rst), .enable(enable2), .pause(pause), .level(level),
    .mole_state(mole_state), .start(start2), .spawn_count(cnt2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst)
    if (rst) frame <= 0;
    else     frame <= frame + 1;

  function automatic logic [15:0] lfsr_n(input int n);
    logic [15:0] l;
    l = 16'hACE1;
    for (int i = 0; i < n; i++)
      l = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    return l;
  endfunction

  function automatic int cand_of(input logic [15:0] v);
    int c;
    c = int'(v[3:0]);
    return (c >= 9) ? c - 9 : c;
  endfunction

  function automatic logic [8:0] onehot(input int c);
    logic [8:0] one;
    one = 9'd1;
    return one << c;
  endfunction

  task automatic push_ev(input int d, input int f, input logic [8:0] s,
                         input logic [7:0] c, input logic b, input int id);
    ev_t e;
    e.dut = d; e.frame = f; e.start = s; e.cnt = c; e.busy = b; e.id = id;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (frame %0d)", name, act, exp, frame);
    end
  endtask

  task automatic check_ev(input int d, input logic [8:0] s, input logic [7:0] c, input logic b);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: dut%0d start=%b cnt=%0d busy=%b frame=%0d, none expected",
               d, s, c, b, frame);
    end else begin
      e = exp_q.pop_front();
      if (e.dut != d || e.frame != frame || e.start !== s || e.cnt !== c || e.busy !== b) begin
        n_fail++;
        $display("FAIL event_%0d: got dut%0d frame=%0d start=%b cnt=%0d busy=%b, expected dut%0d frame=%0d start=%b cnt=%0d busy=%b",
                 e.id, d, frame, s, c, b, e.dut, e.frame, e.start, e.cnt, e.busy);
      end
    end
  endtask

  initial begin
    logic [8:0] prev0, prev1;
    prev0 = '0;
    prev1 = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev0 = '0;
        prev1 = '0;
      end else begin
        if (start1 !== prev0) begin
          check_ev(0, start1, cnt1, busy1);
          prev0 = start1;
        end
        if (start2 !== prev1) begin
          check_ev(1, start2, cnt2, busy2);
          prev1 = start2;
        end
      end
    end
  end

  task automatic do_reset(input logic en, input logic [1:0] lv, input logic [17:0] ms);
    @(negedge clk);
    rst = 1'b1; enable = 1'b0; enable2 = 1'b0; pause = 1'b0;
    level = lv; mole_state = ms;
    repeat (2) @(negedge clk);
    enable = en;
    rst = 1'b0;
  endtask

  task automatic wait_until(input int f);
    while (frame < f) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, c1, c2, rise, e_found, mism;
    logic [17:0] ms;
    rst = 1'b1; enable = 1'b0; enable2 = 1'b0; pause = 1'b0; level = 2'd0; mole_state = '0;

    // First spawn at level 0, accepted two frames after start appears
    do_reset(1'b1, 2'd0, '0);
    check("reset_start", 32'(start1), 32'd0);
    check("reset_count", 32'(cnt1), 32'd0);
    check("reset_busy", 32'(busy1), 32'd0);
    check("reset_start2", 32'(start2), 32'd0);
    check("reset_count2", 32'(cnt2), 32'd0);
    check("reset_busy2", 32'(busy2), 32'd0);
    c = cand_of(lfsr_n(12));
    push_ev(0, 14, onehot(c), 8'd0, 1'b1, 1);
    push_ev(0, 17, 9'd0, 8'd1, 1'b0, 2);
    wait_until(16);
    mole_state[2*c +: 2] = 2'b01;
    wait_until(20);
    check("accept_count", 32'(cnt1), 32'd1);

    // Active cap reached: attempts skipped, PICK visited every 7 frames at level 3
    do_reset(1'b1, 2'd3, 18'h0002A);
    mism = 0;
    for (int f = 1; f <= 100; f++) begin
      wait_until(f);
      if (busy1 !== ((f % 7) == 0)) mism++;
    end
    check("skip_busy_pattern", 32'(mism), 32'd0);
    check("skip_start", 32'(start1), 32'd0);
    check("skip_count", 32'(cnt1), 32'd0);

    // Scan from candidate 6 with only mole 4 empty, then never accepted
    ms = {9{2'b10}};
    ms[9:8] = 2'b00;
    do_reset(1'b0, 2'd0, ms);
    e_found = -1;
    for (int e = 1; e < 2000; e++)
      if (e_found < 0 && cand_of(lfsr_n(e + 12)) == 6) e_found = e;
    check("scan_seed_found", 32'(e_found >= 1), 32'd1);
    if (e_found >= 1) begin
      push_ev(1, e_found + 21, onehot(4), 8'd0, 1'b1, 3);
      push_ev(1, e_found + 37, 9'd0, 8'd0, 1'b0, 4);
      wait_until(e_found);
      enable2 = 1'b1;
      wait_until(e_found + 40);
      enable2 = 1'b0;
      check("timeout_count2", 32'(cnt2), 32'd0);
    end

    // Unaccepted start with 5 paused frames is held 21 frames
    do_reset(1'b1, 2'd0, '0);
    c = cand_of(lfsr_n(12));
    push_ev(0, 14, onehot(c), 8'd0, 1'b1, 5);
    push_ev(0, 35, 9'd0, 8'd0, 1'b0, 6);
    wait_until(18);
    pause = 1'b1;
    wait_until(23);
    pause = 1'b0;
    wait_until(38);
    check("pause_count", 32'(cnt1), 32'd0);

    // Level 3 pacing, then enable dropped mid-ISSUE keeps the count
    do_reset(1'b1, 2'd3, '0);
    c1 = cand_of(lfsr_n(6));
    push_ev(0, 8, onehot(c1), 8'd0, 1'b1, 7);
    push_ev(0, 10, 9'd0, 8'd1, 1'b0, 8);
    c2 = cand_of(lfsr_n(15));
    rise = 17;
    if (c2 == c1) begin
      c2 = (c2 + 1) % 9;
      rise = 18;
    end
    push_ev(0, rise, onehot(c2), 8'd1, 1'b1, 9);
    push_ev(0, 20, 9'd0, 8'd1, 1'b0, 10);
    wait_until(9);
    mole_state[2*c1 +: 2] = 2'b01;
    wait_until(19);
    enable = 1'b0;
    wait_until(24);
    check("disable_count", 32'(cnt1), 32'd1);
    check("disable_busy", 32'(busy1), 32'd0);

    // Level raised mid-WAIT past the new limit, then async reset mid-ISSUE
    do_reset(1'b1, 2'd0, '0);
    c = cand_of(lfsr_n(8));
    push_ev(0, 10, onehot(c), 8'd0, 1'b1, 11);
    wait_until(8);
    level = 2'd3;
    wait_until(12);
    check("issue_before_rst", 32'(start1), 32'(onehot(c)));
    #1 rst = 1'b1;
    #1;
    check("async_rst_start", 32'(start1), 32'd0);
    check("async_rst_busy", 32'(busy1), 32'd0);
    repeat (2) @(negedge clk);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
